// File: rtl/aes_pkg.sv
// Shared AES-128 constants, FSM state type and byte-level helper functions.
package aes_pkg;

  localparam int unsigned NR = 10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ROUND,
    ST_DONE
  } state_t;

  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Forward S-box lookup; byte 0x00 sits in the most significant byte of the table.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[11'd2047 - {b, 3'b000} -: 8];
  endfunction

  // Multiply by x in GF(2^8) modulo the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Round constant for rounds 1..10; zero outside that range.
  function automatic logic [7:0] get_rcon(input logic [3:0] rnd);
    case (rnd)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/aes_iter_ctrl_if.sv
// Job handshake bundle between a producer/consumer and the iterative AES core.
interface aes_iter_ctrl_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] plaintext;
  logic [127:0] key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] ciphertext;
  logic         busy;

  modport master (
    output in_valid, plaintext, key, out_ready,
    input  in_ready, out_valid, ciphertext, busy
  );

  modport slave (
    input  in_valid, plaintext, key, out_ready,
    output in_ready, out_valid, ciphertext, busy
  );
endinterface

// File: rtl/aes_key_step.sv
// One step of the AES-128 key expansion: previous round key -> next round key.
module aes_key_step
  import aes_pkg::*;
(
  input  logic [127:0] rk_prev,
  input  logic [7:0]   rcon,
  output logic [127:0] rk_next
);

  logic [31:0] w_w3;
  logic [31:0] w_temp;
  logic [31:0] w_n0, w_n1, w_n2, w_n3;

  // RotWord + SubWord + Rcon on the last word, then chained XOR across the four words.
  always_comb begin
    w_w3   = rk_prev[31:0];
    w_temp = {sbox(w_w3[23:16]) ^ rcon, sbox(w_w3[15:8]), sbox(w_w3[7:0]), sbox(w_w3[31:24])};
    w_n0   = rk_prev[127:96] ^ w_temp;
    w_n1   = rk_prev[95:64]  ^ w_n0;
    w_n2   = rk_prev[63:32]  ^ w_n1;
    w_n3   = w_w3            ^ w_n2;
    rk_next = {w_n0, w_n1, w_n2, w_n3};
  end

endmodule

// File: rtl/aes_round_comb.sv
// One combinational AES encryption round; the final round skips MixColumns.
module aes_round_comb
  import aes_pkg::*;
#(
  parameter bit FINAL_ROUND = 1'b0
) (
  input  logic [127:0] i_state,
  input  logic [127:0] i_rk,
  output logic [127:0] o_state
);

  logic [7:0] w_sr [0:15];
  logic [7:0] w_mc [0:15];

  // SubBytes + ShiftRows, MixColumns (unless final), AddRoundKey; byte i = r + 4c.
  always_comb begin
    w_sr    = '{default: '0};
    w_mc    = '{default: '0};
    o_state = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        w_sr[4*c+r] = sbox(i_state[127 - 8*(4*((c+r)%4)+r) -: 8]);
      end
    end
    for (int unsigned c = 0; c < 4; c++) begin
      if (FINAL_ROUND) begin
        for (int unsigned r = 0; r < 4; r++) w_mc[4*c+r] = w_sr[4*c+r];
      end else begin
        w_mc[4*c+0] = xtime(w_sr[4*c+0]) ^ xtime(w_sr[4*c+1]) ^ w_sr[4*c+1] ^ w_sr[4*c+2] ^ w_sr[4*c+3];
        w_mc[4*c+1] = w_sr[4*c+0] ^ xtime(w_sr[4*c+1]) ^ xtime(w_sr[4*c+2]) ^ w_sr[4*c+2] ^ w_sr[4*c+3];
        w_mc[4*c+2] = w_sr[4*c+0] ^ w_sr[4*c+1] ^ xtime(w_sr[4*c+2]) ^ xtime(w_sr[4*c+3]) ^ w_sr[4*c+3];
        w_mc[4*c+3] = xtime(w_sr[4*c+0]) ^ w_sr[4*c+0] ^ w_sr[4*c+1] ^ w_sr[4*c+2] ^ xtime(w_sr[4*c+3]);
      end
    end
    for (int unsigned i = 0; i < 16; i++) begin
      o_state[127 - 8*i -: 8] = w_mc[i] ^ i_rk[127 - 8*i -: 8];
    end
  end

endmodule

// File: rtl/aes_iter_ctrl.sv
// Iterative AES-128 encryptor: one round per clock, valid/ready job handshake.
module aes_iter_ctrl
  import aes_pkg::*;
(
  input logic           clk,
  input logic           rst,
  aes_iter_ctrl_if.slave bus
);

  state_t       r_fsm;
  logic [3:0]   r_rnd;
  logic [127:0] r_state;
  logic [127:0] r_rk;
  logic         r_in_ready;
  logic         r_out_valid;
  logic         r_busy;

  logic [7:0]   w_rcon;
  logic [127:0] w_rk_next;
  logic [127:0] w_mid;
  logic [127:0] w_final;
  logic [127:0] w_round;

  assign w_rcon = get_rcon(r_rnd);

  aes_key_step u_key_step (
    .rk_prev (r_rk),
    .rcon    (w_rcon),
    .rk_next (w_rk_next)
  );

  aes_round_comb #(.FINAL_ROUND(1'b0)) u_round_mid (
    .i_state (r_state),
    .i_rk    (w_rk_next),
    .o_state (w_mid)
  );

  aes_round_comb #(.FINAL_ROUND(1'b1)) u_round_final (
    .i_state (r_state),
    .i_rk    (w_rk_next),
    .o_state (w_final)
  );

  assign w_round = (r_rnd == 4'(NR)) ? w_final : w_mid;

  // Control FSM and datapath registers; handshake outputs are registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fsm       <= ST_IDLE;
      r_rnd       <= '0;
      r_state     <= '0;
      r_rk        <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_fsm)
        ST_IDLE: begin
          if (bus.in_valid && r_in_ready) begin
            r_state    <= bus.plaintext ^ bus.key;
            r_rk       <= bus.key;
            r_rnd      <= 4'd1;
            r_fsm      <= ST_ROUND;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        ST_ROUND: begin
          r_state <= w_round;
          r_rk    <= w_rk_next;
          if (r_rnd == 4'(NR)) begin
            r_rnd       <= '0;
            r_fsm       <= ST_DONE;
            r_out_valid <= 1'b1;
          end else begin
            r_rnd <= r_rnd + 4'd1;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            r_fsm       <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_fsm       <= ST_IDLE;
          r_rnd       <= '0;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready   = r_in_ready;
  assign bus.out_valid  = r_out_valid;
  assign bus.busy       = r_busy;
  assign bus.ciphertext = r_state;

endmodule

// File: tb/tb_aes_iter_ctrl.sv
// Directed test of aes_iter_ctrl against FIPS-197 vectors and handshake scenarios.
module tb_aes_iter_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] RK10_C = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] CT_Z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  aes_iter_ctrl_if bus ();

  aes_iter_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accepts one job, scrambles the inputs afterwards, and waits (bounded) for out_valid.
  task automatic do_job(input logic [127:0] pt, input logic [127:0] k,
                        output logic [127:0] ct, output int lat);
    bus.plaintext = pt;
    bus.key       = k;
    bus.in_valid  = 1'b1;
    tick();
    bus.in_valid  = 1'b0;
    bus.plaintext = ~pt;
    bus.key       = ~k;
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    ct = bus.ciphertext;
  endtask

  task automatic test_reset();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.plaintext = '0;
    bus.key       = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    n_checks++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    n_checks++;
    if (bus.ciphertext !== 128'h0) begin n_fail++; $display("FAIL reset_state: got %h expected 0", bus.ciphertext); end
  endtask

  task automatic test_fips_b();
    logic [127:0] ct;
    int lat;
    do_job(PT_B, KEY_B, ct, lat);
    n_checks++;
    if (lat !== 10) begin n_fail++; $display("FAIL appb_latency: got %0d expected 10", lat); end
    n_checks++;
    if (ct !== CT_B) begin n_fail++; $display("FAIL appb_ct: got %h expected %h", ct, CT_B); end
    n_checks++;
    if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL appb_in_ready_done: got %b expected 0", bus.in_ready); end
    n_checks++;
    if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL appb_busy_done: got %b expected 1", bus.busy); end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL appb_out_valid_drop: got %b expected 0", bus.out_valid); end
    n_checks++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL appb_in_ready_idle: got %b expected 1", bus.in_ready); end
    bus.out_ready = 1'b1;
    repeat (3) tick();
    bus.out_ready = 1'b0;
    n_checks++;
    if (bus.ciphertext !== CT_B) begin n_fail++; $display("FAIL idle_hold: got %h expected %h", bus.ciphertext, CT_B); end
    n_checks++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b expected 0", bus.busy); end
  endtask

  task automatic test_fips_c1();
    logic [127:0] ct;
    int lat;
    do_job(PT_C, KEY_C, ct, lat);
    n_checks++;
    if (ct !== CT_C) begin n_fail++; $display("FAIL c1_ct: got %h expected %h", ct, CT_C); end
    n_checks++;
    if (dut.r_rk !== RK10_C) begin n_fail++; $display("FAIL c1_rk10: got %h expected %h", dut.r_rk, RK10_C); end
    n_checks++;
    if (lat !== 10) begin n_fail++; $display("FAIL c1_latency: got %0d expected 10", lat); end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_zero_and_backpressure();
    logic [127:0] ct;
    int lat;
    do_job('0, '0, ct, lat);
    n_checks++;
    if (ct !== CT_Z) begin n_fail++; $display("FAIL zero_ct: got %h expected %h", ct, CT_Z); end
    for (int i = 0; i < 20; i++) begin
      bus.in_valid  = 1'b1;
      bus.plaintext = {$urandom(), $urandom(), $urandom(), $urandom()};
      bus.key       = {$urandom(), $urandom(), $urandom(), $urandom()};
      tick();
      n_checks++;
      if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_out_valid[%0d]: got %b expected 1", i, bus.out_valid); end
      n_checks++;
      if (bus.ciphertext !== CT_Z) begin n_fail++; $display("FAIL stall_ct[%0d]: got %h expected %h", i, bus.ciphertext, CT_Z); end
      n_checks++;
      if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready[%0d]: got %b expected 0", i, bus.in_ready); end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_release: got %b expected 0", bus.out_valid); end
    tick();
    n_checks++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL stall_no_queue: got %b expected 0", bus.busy); end
  endtask

  task automatic test_reset_mid_job();
    logic [127:0] ct;
    int lat;
    bus.plaintext = PT_C;
    bus.key       = KEY_C;
    bus.in_valid  = 1'b1;
    tick();
    bus.in_valid  = 1'b0;
    repeat (4) tick();
    n_checks++;
    if (dut.r_rnd !== 4'd5) begin n_fail++; $display("FAIL midrst_round: got %0d expected 5", dut.r_rnd); end
    rst = 1'b1;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    tick();
    rst = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid: got %b expected 0", bus.out_valid); end
    n_checks++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", bus.busy); end
    n_checks++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready: got %b expected 1", bus.in_ready); end
    n_checks++;
    if (bus.ciphertext !== 128'h0) begin n_fail++; $display("FAIL midrst_state: got %h expected 0", bus.ciphertext); end
    do_job(PT_B, KEY_B, ct, lat);
    n_checks++;
    if (ct !== CT_B) begin n_fail++; $display("FAIL midrst_next_ct: got %h expected %h", ct, CT_B); end
    n_checks++;
    if (lat !== 10) begin n_fail++; $display("FAIL midrst_next_latency: got %0d expected 10", lat); end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [127:0] res [0:1];
    int acc_cyc [0:1];
    int cyc, nacc, nres;
    logic acc;
    res = '{default: '0};
    acc_cyc = '{default: 0};
    cyc = 0; nacc = 0; nres = 0;
    bus.plaintext = PT_B;
    bus.key       = KEY_B;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    while (nres < 2 && cyc < 100) begin
      acc = (bus.in_ready === 1'b1) && (bus.in_valid === 1'b1);
      tick();
      cyc++;
      if (acc && nacc < 2) begin
        acc_cyc[nacc] = cyc;
        nacc++;
        if (nacc == 1) begin
          bus.plaintext = PT_C;
          bus.key       = KEY_C;
        end else begin
          bus.in_valid = 1'b0;
        end
      end
      if (bus.out_valid === 1'b1) begin
        res[nres] = bus.ciphertext;
        nres++;
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    n_checks++;
    if (nres !== 2) begin n_fail++; $display("FAIL b2b_results: got %0d expected 2", nres); end
    n_checks++;
    if (res[0] !== CT_B) begin n_fail++; $display("FAIL b2b_first_ct: got %h expected %h", res[0], CT_B); end
    n_checks++;
    if (res[1] !== CT_C) begin n_fail++; $display("FAIL b2b_second_ct: got %h expected %h", res[1], CT_C); end
    n_checks++;
    if (acc_cyc[1] - acc_cyc[0] !== 12) begin
      n_fail++; $display("FAIL b2b_accept_spacing: got %0d expected 12", acc_cyc[1] - acc_cyc[0]);
    end
  endtask

  initial begin
    test_reset();
    test_fips_b();
    test_fips_c1();
    test_zero_and_backpressure();
    test_reset_mid_job();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
